// File: rtl/operand_fetch.sv
// Operand fetch stage: 32-entry register file, pending-write scoreboard, writeback
// bypass and a single registered operand-pair output slot with valid/ready handshakes.

module of_src_sel #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          pend_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          hazard_o,
  output logic [DW-1:0] data_o
);
  logic nz, hit;

  assign nz  = (addr_i != '0);
  assign hit = wr_en_i && (wr_addr_i == addr_i);

  // A pending source retiring this very cycle is not a hazard: its data is bypassed.
  assign hazard_o = nz && pend_i && !hit;

  always_comb begin
    data_o = '0;
    if (nz) data_o = hit ? wr_data_i : rd_data_i;
  end
endmodule

module operand_fetch #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [CW-1:0] stall_cnt
);
  localparam int NREG = 1 << AW;
  localparam int NSRC = 2;
  localparam logic [CW-1:0] STALL_MAX = '1;

  logic [NREG-1:0][DW-1:0] rf_q;
  logic [NREG-1:0]         pend_q, pend_d;
  logic                    op_vld_q, op_vld_d;
  logic [DW-1:0]           op_a_q, op_b_q;
  logic [CW-1:0]           stall_q, stall_d;

  logic [NSRC-1:0][AW-1:0] src_addr;
  logic [NSRC-1:0]         src_haz;
  logic [NSRC-1:0][DW-1:0] src_data;
  logic                    slot_free, accept;

  assign src_addr = {rt_addr, rs_addr};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    of_src_sel #(.DW(DW), .AW(AW)) u_src (
      .addr_i    (src_addr[g]),
      .rd_data_i (rf_q[src_addr[g]]),
      .pend_i    (pend_q[src_addr[g]]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .hazard_o  (src_haz[g]),
      .data_o    (src_data[g])
    );
  end

  assign slot_free = !op_vld_q || op_ready;
  assign req_ready = slot_free && !(|src_haz);
  assign accept    = req_valid && req_ready;

  // Reservation is applied after the retire clear so a same-address set wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[wr_addr] = 1'b0;
    if (accept && rsv_en) pend_d[rsv_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    op_vld_d = op_vld_q;
    if (accept)        op_vld_d = 1'b1;
    else if (op_ready) op_vld_d = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (req_valid && !req_ready && stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else if (wr_en && wr_addr != '0) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      op_vld_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      stall_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      op_vld_q <= op_vld_d;
      stall_q  <= stall_d;
      if (accept) begin
        op_a_q <= src_data[0];
        op_b_q <= src_data[1];
      end
    end
  end

  assign op_valid  = op_vld_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign stall_cnt = stall_q;
endmodule
